// File: rtl/bus_interrupt_controller_pkg.sv
// Shared definitions for bus_interrupt_controller: register window offsets,
// handshake FSM states and the in-service bit position of the vector register.
package bus_interrupt_controller_pkg;

  // Byte offsets inside the 4-byte register window
  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_MASK    = 2'd1;
  localparam logic [1:0] OFS_VECTOR  = 2'd2;
  localparam logic [1:0] OFS_CLEAR   = 2'd3;

  // Vector register bit that flags "request in service"
  localparam int unsigned VEC_VALID_BIT = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRaise,
    StAcked
  } irq_state_e;

endpackage

// File: rtl/irq_priority_select.sv
// Combinational winner search over a request vector. The search starts at
// start_i and wraps modulo NUM_SRC; start_i = 0 gives fixed lowest-index
// priority, a moving start_i gives rotating priority.
module irq_priority_select #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [2:0]         start_i,
  output logic [2:0]         id_o,
  output logic               valid_o
);

  logic [7:0] req8;
  logic [3:0] sum;
  logic [2:0] idx;

  // Scan NUM_SRC slots from start_i, first requesting slot wins
  always_comb begin
    req8 = '0;
    req8[NUM_SRC-1:0] = req_i;
    id_o    = 3'd0;
    valid_o = 1'b0;
    sum     = 4'd0;
    idx     = 3'd0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      sum = {1'b0, start_i} + 4'(k);
      if (sum >= 4'(NUM_SRC)) begin
        sum = sum - 4'(NUM_SRC);
      end
      idx = sum[2:0];
      if (!valid_o && req8[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/bus_interrupt_controller.sv
// Interrupt controller sharing one CPU interrupt line between NUM_SRC bus
// peripherals. Captures raise edges into a pending register, picks a winner
// among unmasked pending sources, runs the raise/ack handshake with the CPU
// and routes the acknowledge back. Registers live at BASE_ADDR..BASE_ADDR+3
// on a tri-state data bus with one cycle read latency.
// Build option: define ROUND_ROBIN_EN for rotating priority (default: fixed,
// lowest index wins).
module bus_interrupt_controller
  import bus_interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         BUS_ADDR,
  inout  wire  [7:0]         BUS_DATA,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic               CPU_INTERRUPT_RAISE,
  input  logic               CPU_INTERRUPT_ACK
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [7:0]         mask_q, mask_d;
  logic [7:0]         vector_q, vector_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_en_q;

  logic [7:0]         ofs;
  logic               in_win, wr_mask, wr_clear, rd_req;
  logic [7:0]         pending_ext;
  logic [NUM_SRC-1:0] req, svc_src;
  logic [2:0]         start, win_id;
  logic               win_valid, grant, service_done;

  // Address decode; subtraction makes the window independent of alignment
  always_comb begin
    ofs      = BUS_ADDR - BASE_ADDR;
    in_win   = ofs < 8'd4;
    wr_mask  = in_win && BUS_WE && (ofs[1:0] == OFS_MASK);
    wr_clear = in_win && BUS_WE && (ofs[1:0] == OFS_CLEAR);
    rd_req   = in_win && !BUS_WE;
  end

  // Zero-extend pending to the bus width and build the in-service one-hot
  always_comb begin
    pending_ext = '0;
    pending_ext[NUM_SRC-1:0] = pending_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      svc_src[i] = (vector_q[2:0] == 3'(i));
    end
  end

  assign req          = pending_q & mask_q[NUM_SRC-1:0];
  assign grant        = (state_q == StIdle) && win_valid;
  assign service_done = (state_q == StRaise) && CPU_INTERRUPT_ACK;

`ifdef ROUND_ROBIN_EN
  logic [2:0] last_q, last_d;

  // Search starts one past the last granted source, wrapping at NUM_SRC
  always_comb begin
    last_d = grant ? win_id : last_q;
    start  = (({1'b0, last_q} + 4'd1) == 4'(NUM_SRC)) ? 3'd0 : last_q + 3'd1;
  end

  // Last-granted register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_q <= 3'(NUM_SRC - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign start = 3'd0;
`endif

  irq_priority_select #(
    .NUM_SRC (NUM_SRC)
  ) u_irq_priority_select (
    .req_i   (req),
    .start_i (start),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; ACKED gives the source one cycle to drop its level
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_valid) state_d = StRaise;
      StRaise: if (CPU_INTERRUPT_ACK) state_d = StAcked;
      StAcked: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: request held through RAISE, ack pulse during ACKED
  always_comb begin
    CPU_INTERRUPT_RAISE = (state_q == StRaise);
    SRC_ACK             = (state_q == StAcked) ? svc_src : '0;
  end

  // Register next-state; a new raise edge beats any clear in the same cycle
  always_comb begin
    pending_d = pending_q;
    if (service_done) pending_d = pending_d & ~svc_src;
    if (wr_clear)     pending_d = pending_d & ~BUS_DATA[NUM_SRC-1:0];
    pending_d = pending_d | (SRC_IRQ & ~irq_prev_q);

    mask_d = wr_mask ? BUS_DATA : mask_q;

    vector_d = vector_q;
    if (grant) begin
      vector_d = 8'd0;
      vector_d[VEC_VALID_BIT] = 1'b1;
      vector_d[2:0] = win_id;
    end else if (service_done) begin
      vector_d[VEC_VALID_BIT] = 1'b0;
    end

    unique case (ofs[1:0])
      OFS_PENDING: rd_data_d = pending_ext;
      OFS_MASK:    rd_data_d = mask_q;
      OFS_VECTOR:  rd_data_d = vector_q;
      default:     rd_data_d = 8'd0;
    endcase
  end

  // Datapath registers and the registered bus read driver
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_q  <= '0;
      irq_prev_q <= '0;
      mask_q     <= 8'hFF;
      vector_q   <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_en_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= SRC_IRQ;
      mask_q     <= mask_d;
      vector_q   <= vector_d;
      rd_data_q  <= rd_data_d;
      rd_en_q    <= rd_req;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

endmodule
